pio_access_arbiter: RTL and testbench

- Round-robin arbiter sharing one Avalon-MM PIO register slave among NUM_REQ local requesters (HPS bridge, scan sequencer, exposure timer, debug).
- Each requester issues single-word reads or writes over a req/ack handshake. The block serialises them into Avalon slave cycles and returns read data.
- Sits between the scan-control logic and the 32-bit PIO output register.

---
 rtl/pio_arb_pkg.sv | 19 +
 rtl/pio_access_arbiter_rr_pick.sv | 38 +++
 rtl/pio_access_arbiter.sv | 126 ++++++++++++
 tb/tb_pio_access_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO access arbiter.
package pio_arb_pkg;

  // Arbiter FSM states: one slave access every four cycles.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

  // Default widths for the PIO register slave.
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;

  // Word offset of the PIO output data register.
  localparam int DATA_REG = 0;

endpackage

// File: rtl/pio_access_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first asserted request
// strictly after 'last', wrapping around to index 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] above_last;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pool;

  // Mark the positions that come after the previous winner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign above_last[gi] = (IDX_W'(gi) > last);
  end

  assign req_hi = req & above_last;
  // Prefer requests above the pointer; otherwise wrap to the full set.
  assign pool   = (req_hi != '0) ? req_hi : req;
  // Isolate the lowest set bit of the chosen pool.
  assign gnt    = pool & (~pool + NUM_REQ'(1));
  assign any    = (req != '0);

  // Encode the one-hot grant into an index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter serialising single-word requester accesses onto one
// zero-wait Avalon-MM PIO register slave. Every slave output is registered.
module pio_access_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [ADDR_W-1:0]         s_address,
  output logic                      s_chipselect,
  output logic                      s_write_n,
  output logic [DATA_W-1:0]         s_writedata,
  input  logic [DATA_W-1:0]         s_readdata
);

  arb_state_t         state;
  logic [2:0]         last;
  logic [2:0]         idx_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic               wr_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [2:0]         pick_idx;
  logic               pick_any;
  logic               wr_sel;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  wdata_sel;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (3)
  ) u_pick (
    .req (req),
    .last(last),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One-hot AND-OR mux of the winning requester's operands.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        addr_sel  = addr_sel  | req_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata_sel | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_sel = |(req_wr & pick_gnt);

  // Arbitration FSM: IDLE latches a winner, GRANT drives the slave,
  // ACCESS is the single slave cycle, ACK pulses completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last         <= 3'(NUM_REQ - 1);
      idx_reg      <= '0;
      gnt_reg      <= '0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      ack          <= '0;
      rdata        <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      s_address    <= '0;
      s_chipselect <= 1'b0;
      s_write_n    <= 1'b1;
      s_writedata  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            idx_reg   <= pick_idx;
            gnt_reg   <= pick_gnt;
            wr_reg    <= wr_sel;
            addr_reg  <= addr_sel;
            wdata_reg <= wdata_sel;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          s_address    <= addr_reg;
          s_writedata  <= wdata_reg;
          s_chipselect <= 1'b1;
          s_write_n    <= ~wr_reg;
          state        <= ACCESS;
        end
        ACCESS: begin
          // Zero-wait slave: read data is valid during this cycle.
          if (!wr_reg) rdata <= s_readdata;
          s_chipselect <= 1'b0;
          s_write_n    <= 1'b1;
          ack          <= gnt_reg;
          grant_id     <= idx_reg;
          state        <= ACK;
        end
        ACK: begin
          last  <= idx_reg;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Self-checking bench: directed scenarios plus random contention, all
// checked every cycle against a transaction-level reference model.
module tb_pio_access_arbiter;
  import pio_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [2:0]      grant_id;
  logic            busy;
  logic [AW-1:0]   s_address;
  logic            s_chipselect, s_write_n;
  logic [DW-1:0]   s_writedata, s_readdata;

  pio_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .grant_id(grant_id), .busy(busy), .s_address(s_address),
    .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always #5 clk = ~clk;

  // Zero-wait PIO register slave.
  logic [DW-1:0] slave_mem [4] = '{default: '0};
  assign s_readdata = slave_mem[s_address];
  always @(posedge clk) if (s_chipselect && !s_write_n) slave_mem[s_address] <= s_writedata;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, started in a free cycle
  // with a visible request; chipselect two cycles later, ack three later.
  bit            m_active;
  int            m_start, m_idx, m_last = N - 1, m_addr;
  bit            m_wr;
  logic [DW-1:0] m_wdata, m_rdata = '0;
  int            m_gid = 0;
  logic [DW-1:0] m_mem [4] = '{default: '0};
  logic [N-1:0]  obs_ack;
  int            gq[$];

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model();
    logic [N-1:0] e_ack;
    bit e_cs, finishing;
    int ph;
    obs_ack = ack;
    if (!reset_n) begin
      check("rst_ack", ack, 0);          check("rst_busy", busy, 0);
      check("rst_cs", s_chipselect, 0);  check("rst_wn", s_write_n, 1);
      check("rst_rdata", rdata, 0);      check("rst_gid", grant_id, 0);
      check("rst_addr", s_address, 0);   check("rst_wdata", s_writedata, 0);
      m_active = 0; m_last = N - 1; m_rdata = '0; m_gid = 0;
      return;
    end
    e_ack = '0; e_cs = 0; finishing = 0;
    if (m_active) begin
      ph = cyc - m_start;
      if (ph == 2) begin
        e_cs = 1;
        check("s_address", s_address, m_addr);
        check("s_writedata", s_writedata, m_wdata);
        if (m_wr) m_mem[m_addr] = m_wdata;
      end else if (ph == 3) begin
        if (!m_wr) m_rdata = m_mem[m_addr];
        else check("slave_mem", slave_mem[m_addr], m_mem[m_addr]);
        e_ack[m_idx] = 1'b1;
        m_gid = m_idx; m_last = m_idx;
        gq.push_back(m_idx);
        finishing = 1;
      end
    end
    check("ack", ack, e_ack);
    check("busy", busy, m_active);
    check("s_chipselect", s_chipselect, e_cs);
    check("s_write_n", s_write_n, e_cs ? !m_wr : 1'b1);
    check("rdata", rdata, m_rdata);
    check("grant_id", grant_id, m_gid);
    if (finishing) m_active = 0;
    else if (!m_active && req != '0) begin
      m_idx = rr(req, m_last); m_active = 1; m_start = cyc;
      m_wr = req_wr[m_idx];
      m_addr = int'(req_addr[m_idx*AW +: AW]);
      m_wdata = req_wdata[m_idx*DW +: DW];
    end
  endtask

  task automatic step();
    @(negedge clk); model(); cyc++;
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input bit wr, input int addr, input logic [DW-1:0] d);
    req_wr[i] = wr; req_addr[i*AW +: AW] = AW'(addr); req_wdata[i*DW +: DW] = d; req[i] = 1'b1;
  endtask

  task automatic run_until_ack(input int i, input int budget);
    for (int k = 0; k < budget; k++) begin
      step();
      if (obs_ack[i]) break;
    end
    check("ack_wait", obs_ack[i], 1);
    req[i] = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (req == '0 && !m_active) break;
      step();
      for (int i = 0; i < N; i++) if (obs_ack[i]) req[i] = 1'b0;
    end
    check("drain_done", (req == '0 && !m_active), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; step(); step(); reset_n = 1'b1;
  endtask

  bit want [N];
  int exp_order [5] = '{0, 1, 3, 1, 1};

  initial begin
    reset_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    do_reset();

    // Requester 0 writes, then requester 2 reads it back.
    set_op(0, 1, DATA_REG, 32'hDEADBEEF); run_until_ack(0, 8);
    check("t1_out_port", slave_mem[DATA_REG], 32'hDEADBEEF);
    set_op(0, 1, DATA_REG, 32'h12345678); run_until_ack(0, 8);
    set_op(2, 0, DATA_REG, 32'h0);        run_until_ack(2, 8);
    check("t2_rdata", rdata, 32'h12345678);
    $display("directed read/write: rdata=%h", rdata);

    // All four requesters at once, each writing its own index.
    do_reset(); gq.delete();
    for (int i = 0; i < N; i++) set_op(i, 1, DATA_REG, DW'(i));
    drain(40);
    check("t3_count", gq.size(), 4);
    for (int j = 0; j < gq.size() && j < 4; j++) check("t3_order", gq[j], j);
    check("t3_out_port", slave_mem[DATA_REG], 3);
    $display("contention: out_port=%0d", slave_mem[DATA_REG]);

    // Requester 1 holds continuously; 0 and 3 request once.
    gq.delete();
    set_op(0, 1, 1, 32'h100); set_op(1, 1, 1, 32'h101); set_op(3, 1, 1, 32'h103);
    for (int k = 0; k < 60 && gq.size() < 5; k++) begin
      step();
      if (obs_ack[0]) req[0] = 1'b0;
      if (obs_ack[3]) req[3] = 1'b0;
    end
    req[1] = 1'b0; drain(10);
    check("t4_count", gq.size() >= 5, 1);
    for (int j = 0; j < 5 && j < gq.size(); j++) check("t4_order", gq[j], exp_order[j]);

    // Requester 0 drops req right after being sampled.
    set_op(0, 1, 1, 32'hA5A5A5A5); step(); req[0] = 1'b0;
    run_until_ack(0, 8);
    check("t5_write", slave_mem[1], 32'hA5A5A5A5);

    // Reset asserted during ACCESS.
    set_op(0, 1, 2, 32'hCAFEF00D); step(); step();
    reset_n = 1'b0; #1;
    check("t6_cs_drop", s_chipselect, 0);
    step(); step();
    check("t6_no_write", slave_mem[2], m_mem[2]);
    gq.delete(); set_op(1, 1, 3, 32'h11); reset_n = 1'b1;
    drain(20);
    check("t6_prio", (gq.size() > 0) ? gq[0] : -1, 0);
    $display("reset in access: first grant after release=%0d", (gq.size() > 0) ? gq[0] : -1);

    // Random contention with occasional early req drop.
    for (int i = 0; i < N; i++) want[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (want[i]) begin
          if (obs_ack[i]) begin
            want[i] = 0; req[i] = 1'b0;
            $display("txn req=%0d gid=%0d rdata=%h", i, grant_id, rdata);
          end else if (m_active && m_idx == i && cyc - m_start == 1 && $urandom_range(0, 3) == 0)
            req[i] = 1'b0;
        end
        if (!want[i] && $urandom_range(0, 2) == 0) begin
          want[i] = 1;
          set_op(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
        end
      end
      step();
    end
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
